// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and receive-FSM state encoding.
// Used by the deframer, its interface and the bench.
package uart_pkg;

  localparam int OVERSAMPLE_DEFAULT = 16;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx_deframer_if.sv
// uart_rx_deframer_if: serial-side inputs and word-side results of the UART receiver.
// The master side drives the line and ticks; the slave side is the deframer.
interface uart_rx_deframer_if #(
  parameter int DATA_BITS = 8
);
  logic                 BaudTick;
  logic                 RxIn;
  logic                 ParityType;
  logic [DATA_BITS-1:0] DataOut;
  logic                 DoneFlag;
  logic                 ParityError;
  logic                 StopError;
  logic                 Active;

  modport master (
    output BaudTick, RxIn, ParityType,
    input  DataOut, DoneFlag, ParityError, StopError, Active
  );

  modport slave (
    input  BaudTick, RxIn, ParityType,
    output DataOut, DoneFlag, ParityError, StopError, Active
  );
endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the asynchronous serial line.
// Resets to 1 so a reset never looks like a start bit.
module uart_rx_sync (
  input  logic Clock,
  input  logic Reset,
  input  logic RxIn,
  output logic RxSync
);
  logic meta;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      meta   <= 1'b1;
      RxSync <= 1'b1;
    end else begin
      meta   <= RxIn;
      RxSync <= meta;
    end
  end
endmodule

// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: oversampled UART receiver recovering start/data/stop frames.
// Build option: define UART_RX_PARITY_EN to receive and check one parity bit per frame.
//
// state  | meaning
// IDLE   | line idle, waiting for rxs low on a tick
// START  | counting to mid start bit to reject glitches
// DATA   | sampling DATA_BITS payload bits mid-bit, LSB first
// PARITY | sampling the parity bit (parity builds only)
// STOP   | sampling the stop bit, then delivering the word
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input logic               Clock,
  input logic               Reset,
  uart_rx_deframer_if.slave rx
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF_CNT = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic                 rxs;
  logic [2:0]           state;
  logic [CW-1:0]        tickCnt;
  logic [BW-1:0]        bitCnt;
  logic [DATA_BITS-1:0] shiftReg;
`ifdef UART_RX_PARITY_EN
  logic                 parityErr;
`else
  logic                 unusedParityType;
  assign unusedParityType = rx.ParityType;
  assign rx.ParityError   = 1'b0;
`endif

  uart_rx_sync u_sync (
    .Clock  (Clock),
    .Reset  (Reset),
    .RxIn   (rx.RxIn),
    .RxSync (rxs)
  );

  assign rx.Active = (state != ST_IDLE);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= ST_IDLE;
      tickCnt     <= '0;
      bitCnt      <= '0;
      shiftReg    <= '0;
      rx.DataOut  <= '0;
      rx.DoneFlag <= 1'b0;
      rx.StopError <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parityErr      <= 1'b0;
      rx.ParityError <= 1'b0;
`endif
    end else begin
      rx.DoneFlag <= 1'b0;
      if (rx.BaudTick) begin
        tickCnt <= tickCnt + 1'b1;
        case (state)
          ST_IDLE: begin
            tickCnt <= '0;
            if (!rxs) state <= ST_START;
          end
          ST_START: begin
            // Mid start bit: a high line here was only a glitch
            if (tickCnt == HALF_CNT) begin
              tickCnt <= '0;
              bitCnt  <= '0;
              state   <= rxs ? ST_IDLE : ST_DATA;
            end
          end
          ST_DATA: begin
            if (tickCnt == LAST_CNT) begin
              tickCnt  <= '0;
              shiftReg <= {rxs, shiftReg[DATA_BITS-1:1]};
              bitCnt   <= bitCnt + 1'b1;
              if (bitCnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                state <= ST_PARITY;
`else
                state <= ST_STOP;
`endif
              end
            end
          end
`ifdef UART_RX_PARITY_EN
          ST_PARITY: begin
            if (tickCnt == LAST_CNT) begin
              tickCnt   <= '0;
              parityErr <= (^{shiftReg, rxs}) != (rx.ParityType == PARITY_ODD);
              state     <= ST_STOP;
            end
          end
`endif
          ST_STOP: begin
            // Deliver even on a framing error; consumer decides via StopError
            if (tickCnt == LAST_CNT) begin
              tickCnt      <= '0;
              state        <= ST_IDLE;
              rx.DataOut   <= shiftReg;
              rx.StopError <= !rxs;
              rx.DoneFlag  <= 1'b1;
`ifdef UART_RX_PARITY_EN
              rx.ParityError <= parityErr;
`endif
            end
          end
          default: begin
            state   <= ST_IDLE;
            tickCnt <= '0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb_uart_rx_deframer: scoreboard bench; frames are driven bit by bit, expected words
// are queued at stimulus time and a negedge monitor compares each DoneFlag event.
module tb_uart_rx_deframer;
  localparam int DB = 8;
  localparam int OS = 16;
  localparam int TP = 4;  // clocks per BaudTick
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int SAMPLE_TICKS = OS / 2 + (DB + 1 + PB) * OS;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       serr;
    int         doneCyc;
  } exp_t;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t expQ[$];
  exp_t mon;

  uart_rx_deframer_if #(.DATA_BITS(DB)) rx ();

  uart_rx_deframer #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .rx    (rx.slave)
  );

  always #5 Clock = ~Clock;

  initial begin
    rx.BaudTick = 1'b0;
    forever begin
      @(posedge Clock);
      cyc++;
      #1 rx.BaudTick = (cyc % TP == 0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge Clock) begin
    if (!Reset && rx.DoneFlag === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got DoneFlag with DataOut=%0h, expected none", rx.DataOut);
      end else begin
        mon = expQ.pop_front();
        check("data", 32'(rx.DataOut), 32'(mon.data));
        check("parity_error", 32'(rx.ParityError), 32'(mon.perr));
        check("stop_error", 32'(rx.StopError), 32'(mon.serr));
        check("done_cycle", cyc, mon.doneCyc);
      end
    end
  end

  task automatic tick_wait(input int n);
    for (int k = 0; k < n; k++) begin
      do begin
        @(posedge Clock);
        #2;
      end while (rx.BaudTick !== 1'b1);
    end
  endtask

  // Called aligned to a tick; nBits < DB drives a truncated frame and expects nothing.
  task automatic send_frame(input logic [7:0] data, input logic pbit, input logic stopBit,
                            input int nBits);
    exp_t e;
    int   ones;
    ones      = $countones(data) + int'(pbit);
    e.data    = data;
    e.serr    = !stopBit;
    e.perr    = (PB == 1) ? ((ones % 2) != int'(rx.ParityType)) : 1'b0;
    // The tick in the drive cycle precedes rxs going low, so detection is one tick later.
    e.doneCyc = cyc + 1 + TP + SAMPLE_TICKS * TP;
    if (nBits == DB) expQ.push_back(e);
    rx.RxIn = 1'b0;
    tick_wait(OS);
    for (int i = 0; i < nBits; i++) begin
      rx.RxIn = data[i];
      tick_wait(OS);
    end
    if (nBits == DB) begin
      if (PB == 1) begin
        rx.RxIn = pbit;
        tick_wait(OS);
      end
      rx.RxIn = stopBit;
      tick_wait(OS);
      rx.RxIn = 1'b1;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_data"}, 32'(rx.DataOut), 32'h0);
    check({tag, "_done"}, 32'(rx.DoneFlag), 32'h0);
    check({tag, "_perr"}, 32'(rx.ParityError), 32'h0);
    check({tag, "_serr"}, 32'(rx.StopError), 32'h0);
    check({tag, "_active"}, 32'(rx.Active), 32'h0);
  endtask

  task automatic drain(input int budget);
    int waited;
    waited = 0;
    while (expQ.size() != 0 && waited < budget) begin
      @(posedge Clock);
      waited++;
    end
    check("drain_pending", 32'(expQ.size()), 32'h0);
  endtask

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic       sb;
    rx.RxIn       = 1'b1;
    rx.ParityType = 1'b0;
    repeat (3) @(posedge Clock);
    #2;
    check_idle_outputs("reset");
    Reset = 1'b0;
    tick_wait(2 * OS);

    send_frame(8'hA5, 1'b0, 1'b1, DB);
    tick_wait(OS);
    drain(200);

    // Reset in the middle of 0x5A, then a clean 0x3C
    send_frame(8'h5A, 1'b0, 1'b1, 3);
    check("midframe_active", 32'(rx.Active), 32'h1);
    Reset = 1'b1;
    repeat (2) @(posedge Clock);
    #2;
    check_idle_outputs("midreset");
    rx.RxIn = 1'b1;
    repeat (3) @(posedge Clock);
    #2;
    check("midreset_done_hold", 32'(rx.DoneFlag), 32'h0);
    Reset = 1'b0;
    tick_wait(2 * OS);
    send_frame(8'h3C, 1'b0, 1'b1, DB);
    tick_wait(OS);
    drain(200);

`ifdef UART_RX_PARITY_EN
    rx.ParityType = 1'b0;
    send_frame(8'h07, 1'b1, 1'b1, DB);
    tick_wait(2);
    send_frame(8'h07, 1'b0, 1'b1, DB);
    tick_wait(2);
    drain(200);
`endif

    send_frame(8'h81, 1'b1, 1'b0, DB);
    tick_wait(2 * OS);
    send_frame(8'h42, 1'b0, 1'b1, DB);
    tick_wait(OS);
    drain(200);

    // False start: four low ticks only
    rx.RxIn = 1'b0;
    tick_wait(2);
    check("false_start_active", 32'(rx.Active), 32'h1);
    tick_wait(2);
    rx.RxIn = 1'b1;
    tick_wait(OS);
    check("false_start_idle", 32'(rx.Active), 32'h0);
    send_frame(8'h33, 1'b0, 1'b1, DB);
    tick_wait(OS);
    drain(200);

    send_frame(8'h11, 1'b1, 1'b1, DB);
    send_frame(8'hEE, 1'b0, 1'b1, DB);
    tick_wait(OS);
    drain(200);

    for (int n = 0; n < 12; n++) begin
      d  = 8'($urandom_range(0, 255));
      sb = ($urandom_range(0, 3) != 0);
      rx.ParityType = 1'($urandom_range(0, 1));
      send_frame(d, 1'($urandom_range(0, 1)), sb, DB);
      if (!sb) tick_wait(2 * OS);
      else tick_wait($urandom_range(0, 3));
    end
    tick_wait(OS);
    drain(400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
